// File: rtl/biriscv_multiplier_pipe_pkg.sv
// Shared RV32M/RV64M multiply encodings used by the decode, issue and execute logic.
// Match values are built from the funct3 encodings so the two can never disagree.
package biriscv_multiplier_pipe_pkg;

    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'd0,
        FUNCT3_MULH   = 3'd1,
        FUNCT3_MULHSU = 3'd2,
        FUNCT3_MULHU  = 3'd3
    } mul_funct3_e;

    localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    // One mask covers all four variants: funct7, funct3 and the major opcode.
    localparam logic [31:0] INST_MUL_MASK = 32'hfe00707f;

    localparam logic [31:0] INST_MUL    = {FUNCT7_MULDIV, 10'b0, FUNCT3_MUL,    5'b0, OPCODE_OP};
    localparam logic [31:0] INST_MULH   = {FUNCT7_MULDIV, 10'b0, FUNCT3_MULH,   5'b0, OPCODE_OP};
    localparam logic [31:0] INST_MULHSU = {FUNCT7_MULDIV, 10'b0, FUNCT3_MULHSU, 5'b0, OPCODE_OP};
    localparam logic [31:0] INST_MULHU  = {FUNCT7_MULDIV, 10'b0, FUNCT3_MULHU,  5'b0, OPCODE_OP};

    // Result select: high half of the double-width product.
    localparam logic MUL_SEL_HI = 1'b1;

endpackage

// File: rtl/biriscv_mul_decode.sv
// Combinational decode of a raw instruction word into multiply control.
// Shared between the issue logic and the multiply pipeline.
module biriscv_mul_decode
    import biriscv_multiplier_pipe_pkg::*;
(
    input  logic [31:0] opcode,
    output logic        is_mul,
    output logic        a_signed,
    output logic        b_signed,
    output logic        sel_hi
);

    logic [31:0] masked;

    assign masked = opcode & INST_MUL_MASK;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
        is_mul   = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        sel_hi   = 1'b0;
        case (masked)
            INST_MUL: begin
                is_mul = 1'b1;
            end
            INST_MULH: begin
                is_mul   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
                sel_hi   = MUL_SEL_HI;
            end
            INST_MULHSU: begin
                is_mul   = 1'b1;
                a_signed = 1'b1;
                sel_hi   = MUL_SEL_HI;
            end
            INST_MULHU: begin
                is_mul   = 1'b1;
                sel_hi   = MUL_SEL_HI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/biriscv_multiplier_pipe.sv
// Pipelined RV32M/RV64M multiply unit: 1..3 stages, stall via hold_i, kill via flush_i.
// Bubbles carry zero operands, so an idle slot always produces a zero result.
module biriscv_multiplier_pipe
    import biriscv_multiplier_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic [XLEN-1:0] writeback_value_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("biriscv_multiplier_pipe: XLEN must be 32 or 64");
        end
        if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
            $error("biriscv_multiplier_pipe: STAGES must be 1, 2 or 3");
        end
    endgenerate

    logic is_mul, a_signed, b_signed, sel_hi;

    biriscv_mul_decode u_decode (
        .opcode   (opcode_opcode_i),
        .is_mul   (is_mul),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .sel_hi   (sel_hi)
    );

    logic            accept;
    logic [XLEN:0]   in_a, in_b;

    assign accept = opcode_valid_i & is_mul;
    assign in_a   = accept ? {a_signed & opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i} : '0;
    assign in_b   = accept ? {b_signed & opcode_rb_operand_i[XLEN-1], opcode_rb_operand_i} : '0;

    // Multiplier inputs (either the raw inputs or the E1 register) and its result.
    logic              m_valid, m_sel_hi;
    logic [4:0]        m_rd;
    logic [XLEN:0]     m_a, m_b;
    logic [2*XLEN-1:0] m_product;
    logic [XLEN-1:0]   m_result;

    // Sign-extending to 2*XLEN and truncating gives the signed (XLEN+1)-bit product mod 2^(2*XLEN).
    assign m_product = {{(XLEN-1){m_a[XLEN]}}, m_a} * {{(XLEN-1){m_b[XLEN]}}, m_b};
    assign m_result  = m_sel_hi ? m_product[2*XLEN-1:XLEN] : m_product[XLEN-1:0];

    // Feeds the output register.
    logic            res_valid;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_value;

    generate
        if (STAGES == 1) begin : g_no_e1
            assign m_valid  = accept;
            assign m_rd     = accept ? opcode_rd_idx_i : '0;
            assign m_a      = in_a;
            assign m_b      = in_b;
            assign m_sel_hi = accept & sel_hi;
        end else begin : g_e1
            logic            e1_valid, e1_sel_hi;
            logic [4:0]      e1_rd;
            logic [XLEN:0]   e1_a, e1_b;

            always_ff @(posedge clk_i) begin
                // NOTE: non-blocking assignments so each stage captures its upstream value from before the edge.
                if (rst_i || flush_i) begin
                    e1_valid  <= 1'b0;
                    e1_rd     <= '0;
                    e1_a      <= '0;
                    e1_b      <= '0;
                    e1_sel_hi <= 1'b0;
                end else if (!hold_i) begin
                    e1_valid  <= accept;
                    e1_rd     <= accept ? opcode_rd_idx_i : '0;
                    e1_a      <= in_a;
                    e1_b      <= in_b;
                    e1_sel_hi <= accept & sel_hi;
                end
            end

            assign m_valid  = e1_valid;
            assign m_rd     = e1_rd;
            assign m_a      = e1_a;
            assign m_b      = e1_b;
            assign m_sel_hi = e1_sel_hi;
        end

        if (STAGES == 3) begin : g_e2
            logic            e2_valid;
            logic [4:0]      e2_rd;
            logic [XLEN-1:0] e2_value;

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    e2_valid <= 1'b0;
                    e2_rd    <= '0;
                    e2_value <= '0;
                end else if (!hold_i) begin
                    e2_valid <= m_valid;
                    e2_rd    <= m_rd;
                    e2_value <= m_result;
                end
            end

            assign res_valid = e2_valid;
            assign res_rd    = e2_rd;
            assign res_value = e2_value;
        end else begin : g_no_e2
            assign res_valid = m_valid;
            assign res_rd    = m_rd;
            assign res_value = m_result;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            writeback_valid_o  <= 1'b0;
            writeback_rd_idx_o <= '0;
            writeback_value_o  <= '0;
        end else if (!hold_i) begin
            writeback_valid_o  <= res_valid;
            writeback_rd_idx_o <= res_rd;
            writeback_value_o  <= res_value;
        end
    end

endmodule

// File: tb/tb_biriscv_multiplier_pipe.sv
// Scoreboard bench: four instances (32b x STAGES 1/2/3, 64b x STAGES 2) share one stimulus stream.
// A posedge model pushes expected results; a negedge monitor pops and compares.
module tb_biriscv_multiplier_pipe;

    localparam int N = 4;
    localparam int STG [N] = '{1, 2, 3, 2};
    localparam int XL  [N] = '{32, 32, 32, 64};

    logic        clk = 1'b0;
    logic        rst, valid, hold, flush;
    logic [31:0] opcode;
    logic [4:0]  rd;
    logic [63:0] ra, rb;

    logic        wb_valid [N];
    logic [4:0]  wb_rd    [N];
    logic [31:0] v32      [3];
    logic [63:0] v64;
    logic [63:0] wb_val   [N];

    always #5 clk = ~clk;

    biriscv_multiplier_pipe #(.XLEN(32), .STAGES(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid[0]),
        .writeback_rd_idx_o(wb_rd[0]), .writeback_value_o(v32[0]));

    biriscv_multiplier_pipe #(.XLEN(32), .STAGES(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid[1]),
        .writeback_rd_idx_o(wb_rd[1]), .writeback_value_o(v32[1]));

    biriscv_multiplier_pipe #(.XLEN(32), .STAGES(3)) u_s3 (
        .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra[31:0]), .opcode_rb_operand_i(rb[31:0]),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid[2]),
        .writeback_rd_idx_o(wb_rd[2]), .writeback_value_o(v32[2]));

    biriscv_multiplier_pipe #(.XLEN(64), .STAGES(2)) u_x64 (
        .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opcode),
        .opcode_rd_idx_i(rd), .opcode_ra_operand_i(ra), .opcode_rb_operand_i(rb),
        .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid[3]),
        .writeback_rd_idx_o(wb_rd[3]), .writeback_value_o(v64));

    assign wb_val[0] = {32'b0, v32[0]};
    assign wb_val[1] = {32'b0, v32[1]};
    assign wb_val[2] = {32'b0, v32[2]};
    assign wb_val[3] = v64;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int dut, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, dut, $time, act, exp);
        end
    endtask

    // Reference: 0=MUL 1=MULH 2=MULHSU 3=MULHU, -1 for anything else.
    function automatic int tb_kind(input logic [31:0] op);
        if (op[6:0] == 7'b0110011 && op[31:25] == 7'b0000001 && op[14:12] < 3'd4)
            return int'(op[14:12]);
        return -1;
    endfunction

    function automatic logic [63:0] ref_mul(input int kind, input logic [63:0] a, input logic [63:0] b, input int xlen);
        logic signed [129:0] ea, eb, p;
        logic sa, sb;
        sa = (kind == 1 || kind == 2);
        sb = (kind == 1);
        if (xlen == 32) begin
            ea = {{98{sa & a[31]}}, a[31:0]};
            eb = {{98{sb & b[31]}}, b[31:0]};
        end else begin
            ea = {{66{sa & a[63]}}, a};
            eb = {{66{sb & b[63]}}, b};
        end
        p = ea * eb;
        if (xlen == 32) return (kind == 0) ? {32'b0, p[31:0]} : {32'b0, p[63:32]};
        return (kind == 0) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [31:0] mk_op(input int kind, input logic [4:0] dst);
        logic [2:0] f;
        f = kind[2:0];
        return {7'b0000001, 5'd11, 5'd10, f, dst, 7'b0110011};
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] val;
        int          adv;
    } exp_t;

    exp_t sb [N][$];
    int   adv = 0;          // count of non-held, non-cleared edges
    bit   held_edge = 1'b0;
    bit   mon_en = 1'b0;

    // Model: at each edge, decide what the unit accepted.
    always @(posedge clk) begin
        int kind;
        held_edge = 1'b0;
        if (rst || flush) begin
            for (int i = 0; i < N; i++) sb[i].delete();
        end else if (hold) begin
            held_edge = 1'b1;
        end else begin
            adv++;
            kind = tb_kind(opcode);
            if (valid && kind >= 0)
                for (int i = 0; i < N; i++) sb[i].push_back('{rd, ref_mul(kind, ra, rb, XL[i]), adv});
        end
    end

    logic        prev_valid [N];
    logic [4:0]  prev_rd    [N];
    logic [63:0] prev_val   [N];

    // Monitor: result for an op accepted with count c is due when adv == c + STAGES - 1.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mon_en) begin
                if (held_edge) begin
                    check("hold_valid", i, {63'b0, wb_valid[i]}, {63'b0, prev_valid[i]});
                    check("hold_rd", i, {59'b0, wb_rd[i]}, {59'b0, prev_rd[i]});
                    check("hold_value", i, wb_val[i], prev_val[i]);
                end else begin
                    logic due;
                    exp_t e;
                    due = (sb[i].size() > 0) && ((adv - sb[i][0].adv) >= STG[i] - 1);
                    check("valid", i, {63'b0, wb_valid[i]}, {63'b0, due});
                    if (due) begin
                        e = sb[i].pop_front();
                        if (wb_valid[i]) begin
                            check("rd", i, {59'b0, wb_rd[i]}, {59'b0, e.rd});
                            check("value", i, wb_val[i], e.val);
                        end
                    end
                    if (!wb_valid[i]) check("bubble_value", i, wb_val[i], 64'd0);
                end
            end
            prev_valid[i] = wb_valid[i];
            prev_rd[i]    = wb_rd[i];
            prev_val[i]   = wb_val[i];
        end
    end

    task automatic idle(input int n);
        valid = 1'b0; opcode = '0; rd = '0; ra = '0; rb = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] op, input logic [4:0] dst, input logic [63:0] a, input logic [63:0] b);
        valid = 1'b1; opcode = op; rd = dst; ra = a; rb = b;
        @(negedge clk);
    endtask

    // Direct check on the STAGES=2 instances: the result is visible two negedges after issue.
    task automatic directed(input int kind, input logic [63:0] a, input logic [63:0] b,
                            input logic [31:0] e32, input bit do64, input logic [63:0] e64);
        logic [4:0] dst;
        dst = 5'(kind + 9);
        issue(mk_op(kind, dst), dst, a, b);
        idle(1);
        check("dir_valid", 1, {63'b0, wb_valid[1]}, 64'd1);
        check("dir_rd", 1, {59'b0, wb_rd[1]}, {59'b0, dst});
        check("dir_value", 1, wb_val[1], {32'b0, e32});
        if (do64) check("dir_value64", 3, wb_val[3], e64);
        idle(3);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        valid = 1'b0; opcode = '0; rd = '0; ra = '0; rb = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_valid", i, {63'b0, wb_valid[i]}, 64'd0);
            check("reset_rd", i, {59'b0, wb_rd[i]}, 64'd0);
            check("reset_value", i, wb_val[i], 64'd0);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        directed(0, 64'h7, 64'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 64'd0);
        directed(1, 64'h8000_0000, 64'h8000_0000, 32'h4000_0000, 1'b0, 64'd0);
        directed(3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 64'd0);
        directed(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0);
        directed(3, '1, '1, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);

        // Back-to-back MULs, rd 1..3.
        issue(mk_op(0, 5'd1), 5'd1, 64'd3, 64'd5);
        issue(mk_op(0, 5'd2), 5'd2, 64'hFFFF_FFFF, 64'd2);
        issue(mk_op(0, 5'd3), 5'd3, 64'h1234_5678, 64'h9ABC_DEF0);
        idle(5);

        // Two ops in flight, then hold for two cycles.
        issue(mk_op(1, 5'd4), 5'd4, 64'h8000_0001, 64'h7FFF_FFFF);
        issue(mk_op(2, 5'd5), 5'd5, 64'hDEAD_BEEF, 64'hCAFE_F00D);
        idle(0);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b0;
        idle(5);

        // Two ops in flight, flush with a concurrent MUL, then a MUL that must complete.
        issue(mk_op(0, 5'd6), 5'd6, 64'd11, 64'd13);
        issue(mk_op(3, 5'd7), 5'd7, 64'hFFFF_0000, 64'h0001_FFFF);
        flush = 1'b1;
        issue(mk_op(0, 5'd8), 5'd8, 64'd17, 64'd19);
        flush = 1'b0;
        for (int i = 0; i < N; i++) check("flush_valid", i, {63'b0, wb_valid[i]}, 64'd0);
        issue(mk_op(0, 5'd10), 5'd10, 64'd21, 64'd23);
        idle(5);

        // Non-multiply opcodes with valid high.
        issue(32'h00B5_0533, 5'd10, 64'd5, 64'd6);
        idle(1);
        check("add_valid", 1, {63'b0, wb_valid[1]}, 64'd0);
        check("add_value", 1, wb_val[1], 64'd0);
        issue(mk_op(4, 5'd12), 5'd12, 64'd100, 64'd7);
        idle(4);

        // Reset mid-flight.
        issue(mk_op(0, 5'd13), 5'd13, 64'd9, 64'd9);
        rst = 1'b1;
        issue(mk_op(1, 5'd14), 5'd14, 64'd9, 64'd9);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("midrst_valid", i, {63'b0, wb_valid[i]}, 64'd0);
            check("midrst_rd", i, {59'b0, wb_rd[i]}, 64'd0);
            check("midrst_value", i, wb_val[i], 64'd0);
        end
        idle(4);

        // Randomized traffic with occasional hold, flush and reset.
        for (int c = 0; c < 600; c++) begin
            int r;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            valid = ($urandom_range(0, 4) != 0);
            rd    = 5'($urandom);
            ra    = pick();
            rb    = pick();
            r     = $urandom_range(0, 9);
            if (r < 7)       opcode = mk_op(r % 4, rd);
            else if (r == 7) opcode = 32'h00B5_0533;
            else if (r == 8) opcode = mk_op($urandom_range(4, 7), rd);
            else             opcode = $urandom;
            @(negedge clk);
        end
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        idle(8);

        for (int i = 0; i < N; i++) check("drained", i, 64'(sb[i].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
